// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_string_handle-side signals of uart_tx_arbiter.
// master = arbiter view, slave = requesters plus downstream TX channel.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned STR_W = 1024
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*STR_W-1:0] req_string;
    logic [N_REQ*8-1:0]     req_length;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       req_done;
    logic [2:0]             grant_id;
    logic                   arb_busy;
    logic [STR_W-1:0]       tx_string;
    logic [7:0]             tx_length;
    logic                   tx_req;
    logic                   tx_busy;
    logic                   tx_done;

    modport master (
        input  req_valid, req_string, req_length, tx_busy, tx_done,
        output req_ack, req_done, grant_id, arb_busy, tx_string, tx_length, tx_req
    );

    modport slave (
        output req_valid, req_string, req_length, tx_busy, tx_done,
        input  req_ack, req_done, grant_id, arb_busy, tx_string, tx_length, tx_req
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_string_handle TX channel among N_REQ requesters (round-robin, idle gap after each frame).
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned STR_W      = 1024,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned ID_W    = 3;
    localparam int unsigned SUM_W   = ID_W + 1;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAX_LEN = (STR_W / 8 > 255) ? 255 : STR_W / 8;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef UART_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               arb_busy_q, arb_busy_d;
    logic [STR_W-1:0]   tx_string_q, tx_string_d;
    logic [LEN_W-1:0]   tx_length_q, tx_length_d;
    logic               tx_req_q, tx_req_d;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic [N_REQ-1:0]   req_done_q, req_done_d;

    logic [N_REQ-1:0]   rot_c;
    logic               win_found_c;
    logic [ID_W-1:0]    win_idx_c;
    logic [N_REQ-1:0]   win_onehot_c;
    logic [LEN_W-1:0]   win_len_c;
    logic [STR_W-1:0]   win_str_c;

    // (base + ofs) mod N_REQ for base, ofs < N_REQ
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] ofs);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
        return sum[ID_W-1:0];
    endfunction

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] owner);
        return FIXED_PRIO ? '0 : wrap_add(owner, ID_W'(1));
    endfunction

    // Rotate requests so bit 0 is the highest-priority slot, then take the first set bit.
    always_comb begin
        rot_c       = N_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!win_found_c && rot_c[i]) begin
                win_found_c = 1'b1;
                win_idx_c   = wrap_add(rr_ptr_q, ID_W'(i));
            end
        end
    end

    always_comb begin
        win_len_c = '0;
        win_str_c = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_idx_c == ID_W'(k)) begin
                win_len_c = bus.req_length[k*LEN_W +: LEN_W];
                win_str_c = bus.req_string[k*STR_W +: STR_W];
            end
        end
    end

    assign win_onehot_c = N_REQ'(1) << win_idx_c;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gap_cnt_q   <= '0;
            grant_id_q  <= '0;
            arb_busy_q  <= 1'b0;
            tx_string_q <= '0;
            tx_length_q <= '0;
            tx_req_q    <= 1'b0;
            req_ack_q   <= '0;
            req_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            grant_id_q  <= grant_id_d;
            arb_busy_q  <= arb_busy_d;
            tx_string_q <= tx_string_d;
            tx_length_q <= tx_length_d;
            tx_req_q    <= tx_req_d;
            req_ack_q   <= req_ack_d;
            req_done_q  <= req_done_d;
        end
    end

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gap_cnt_d   = gap_cnt_q;
        grant_id_d  = grant_id_q;
        arb_busy_d  = arb_busy_q;
        tx_string_d = tx_string_q;
        tx_length_d = tx_length_q;
        tx_req_d    = 1'b0;
        req_ack_d   = '0;
        req_done_d  = '0;

        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    req_ack_d = win_onehot_c;
                    if (win_len_c == '0) begin
                        // Empty frame: acknowledged and completed without touching the channel.
                        req_done_d = win_onehot_c;
                        rr_ptr_d   = ptr_after(win_idx_c);
                    end else begin
                        grant_id_d  = win_idx_c;
                        arb_busy_d  = 1'b1;
                        tx_string_d = win_str_c;
                        tx_length_d = (win_len_c > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : win_len_c;
                        state_d     = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (!bus.tx_busy) begin
                    tx_req_d = 1'b1;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    req_done_d = N_REQ'(1) << grant_id_q;
                    rr_ptr_d   = ptr_after(grant_id_q);
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        state_d   = GAP;
                    end else begin
                        arb_busy_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    arb_busy_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.req_done  = req_done_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.arb_busy  = arb_busy_q;
    assign bus.tx_string = tx_string_q;
    assign bus.tx_length = tx_length_q;
    assign bus.tx_req    = tx_req_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level reference model compared every cycle, plus directed scenarios.
// Define UART_ARB_FIXED_PRIO_EN for both files to exercise the fixed-priority build.
module tb_uart_tx_arbiter;
    localparam int unsigned N_REQ      = 4;
    localparam int unsigned STR_W      = 1024;
    localparam int unsigned GAP_CYCLES = 16;
    localparam int unsigned MAX_LEN    = STR_W / 8;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .STR_W(STR_W)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .STR_W(STR_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.master)
    );

    // Requester and downstream stimulus state
    logic [STR_W-1:0] r_str [N_REQ];
    logic [7:0]       r_len [N_REQ];
    logic [N_REQ-1:0] r_val;
    bit               auto_refill, rand_mode, ds_run;
    int               ds_left, hold_busy;
    logic             tx_busy_i, tx_done_i;

    // Reference model: who owns the channel, whether its frame was launched, gap cycles left
    int               m_owner, m_rr, m_gap_left;
    bit               m_launched;
    logic [N_REQ-1:0] e_ack, e_done;
    logic             e_txreq, e_busy;
    logic [2:0]       e_gid;
    logic [7:0]       e_txlen;
    logic [STR_W-1:0] e_txstr;

    int checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [STR_W-1:0] rand_str();
        logic [STR_W-1:0] s;
        for (int i = 0; i < int'(STR_W / 32); i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [7:0] rand_len(input bit allow_zero);
        int unsigned r;
        r = $urandom_range(0, 9);
        if (allow_zero && r == 0) return 8'd0;
        if (r == 1) return 8'($urandom_range(129, 255));
        return 8'($urandom_range(1, 128));
    endfunction

    function automatic int rr_after(input int k);
`ifdef UART_ARB_FIXED_PRIO_EN
        return 0 * k;
`else
        return (k + 1) % N_REQ;
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_gap_left = -1; m_launched = 0;
        e_ack = '0; e_done = '0; e_txreq = 0; e_busy = 0;
        e_gid = '0; e_txlen = '0; e_txstr = '0;
    endtask

    // Expected outputs after the next edge, from the inputs that edge will sample
    task automatic model_step();
        int k;
        e_ack = '0; e_done = '0; e_txreq = 0;
        if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                m_gap_left = -1; m_owner = -1; e_busy = 0;
            end
        end else if (m_owner < 0) begin
            k = -1;
            for (int i = 0; i < N_REQ; i++)
                if (k < 0 && r_val[(m_rr + i) % N_REQ]) k = (m_rr + i) % N_REQ;
            if (k >= 0) begin
                e_ack[k] = 1'b1;
                if (r_len[k] == 0) begin
                    e_done[k] = 1'b1;
                    m_rr = rr_after(k);
                end else begin
                    m_owner = k; m_launched = 0; e_busy = 1;
                    e_gid   = 3'(k);
                    e_txlen = (r_len[k] > MAX_LEN) ? 8'(MAX_LEN) : r_len[k];
                    e_txstr = r_str[k];
                end
            end
        end else if (!m_launched) begin
            if (!tx_busy_i) begin
                e_txreq = 1; m_launched = 1;
            end
        end else if (tx_done_i) begin
            e_done[m_owner] = 1'b1;
            m_rr = rr_after(m_owner);
            if (GAP_CYCLES > 0) m_gap_left = GAP_CYCLES;
            else begin m_owner = -1; e_busy = 0; end
        end
    endtask

    task automatic drive_inputs();
        bus.req_valid = r_val;
        for (int k = 0; k < N_REQ; k++) begin
            bus.req_string[k*STR_W +: STR_W] = r_str[k];
            bus.req_length[k*8 +: 8]         = r_len[k];
        end
        bus.tx_busy = tx_busy_i;
        bus.tx_done = tx_done_i;
    endtask

    task automatic compare_all();
        chk("req_ack",   64'(bus.req_ack),   64'(e_ack));
        chk("req_done",  64'(bus.req_done),  64'(e_done));
        chk("tx_req",    64'(bus.tx_req),    64'(e_txreq));
        chk("arb_busy",  64'(bus.arb_busy),  64'(e_busy));
        chk("tx_length", 64'(bus.tx_length), 64'(e_txlen));
        if (e_busy) chk("grant_id", 64'(bus.grant_id), 64'(e_gid));
        checks++;
        if (bus.tx_string !== e_txstr) begin
            failures++;
            $display("FAIL tx_string cycle=%0d actual_lo=%0h expected_lo=%0h",
                     cyc, bus.tx_string[63:0], e_txstr[63:0]);
        end
    endtask

    // One clock: apply inputs, predict, pass the edge, compare, then react as requesters/downstream
    task automatic tick();
        drive_inputs();
        model_step();
        @(negedge sys_clk);
        cyc++;
        compare_all();
        for (int k = 0; k < N_REQ; k++) begin
            if (e_ack[k]) begin
                if (auto_refill || (rand_mode && $urandom_range(0, 1) == 1)) begin
                    r_len[k] = rand_len(!auto_refill);
                    r_str[k] = rand_str();
                end else begin
                    r_val[k] = 1'b0;
                end
            end
        end
        tx_done_i = 1'b0;
        if (ds_run) begin
            if (ds_left == 0) begin
                tx_done_i = 1'b1; tx_busy_i = 1'b0; ds_run = 0;
            end else begin
                ds_left--; tx_busy_i = 1'b1;
            end
        end else if (e_txreq) begin
            ds_run = 1; tx_busy_i = 1'b1;
            ds_left = rand_mode ? int'($urandom_range(0, 6)) : 3;
        end else if (hold_busy > 0) begin
            hold_busy--; tx_busy_i = 1'b1;
        end else begin
            tx_busy_i = 1'b0;
            if (rand_mode) begin
                tx_busy_i = ($urandom_range(0, 4) == 0);
                tx_done_i = ($urandom_range(0, 9) == 0);
            end
        end
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_req_ack",   64'(bus.req_ack),   64'd0);
        chk("rst_req_done",  64'(bus.req_done),  64'd0);
        chk("rst_tx_req",    64'(bus.tx_req),    64'd0);
        chk("rst_arb_busy",  64'(bus.arb_busy),  64'd0);
        chk("rst_grant_id",  64'(bus.grant_id),  64'd0);
        chk("rst_tx_length", 64'(bus.tx_length), 64'd0);
        chk("rst_tx_str_lo", bus.tx_string[63:0], 64'd0);
        model_reset();
        ds_run = 0; ds_left = 0; hold_busy = 0;
        tx_busy_i = 1'b0; tx_done_i = 1'b0;
        drive_inputs();
        @(negedge sys_clk);
        cyc++;
        compare_all();
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, first, cnt, nack, last_done, min_gap;
        int seq [5];
        sys_rst_n = 1'b0;
        r_val = '0; auto_refill = 0; rand_mode = 0;
        for (int k = 0; k < N_REQ; k++) begin r_str[k] = '0; r_len[k] = '0; end
        model_reset();
        ds_run = 0; ds_left = 0; hold_busy = 0; tx_busy_i = 0; tx_done_i = 0;
        drive_inputs();
        repeat (2) @(negedge sys_clk);
        do_reset();

        // Single request on slot 2, length 5
        r_val[2] = 1'b1; r_len[2] = 8'd5; r_str[2] = rand_str();
        tick();
        chk("s1_ack_t1",  64'(bus.req_ack),  64'h4);
        chk("s1_busy_t1", 64'(bus.arb_busy), 64'd1);
        tick();
        chk("s1_txreq_t2", 64'(bus.tx_req),    64'd1);
        chk("s1_txlen",    64'(bus.tx_length), 64'd5);
        n = 0;
        while (bus.req_done[2] !== 1'b1 && n < 50) begin tick(); n++; end
        chk("s1_done_seen", 64'(n < 50), 64'd1);
        n = 0;
        while (bus.arb_busy === 1'b1 && n < 40) begin tick(); n++; end
        chk("s1_gap_cycles", 64'(n), 64'd16);

        // Zero-length request on slot 1
        do_reset();
        r_val[1] = 1'b1; r_len[1] = 8'd0;
        tick();
        chk("s3_ack",  64'(bus.req_ack),  64'h2);
        chk("s3_done", 64'(bus.req_done), 64'h2);
        chk("s3_busy", 64'(bus.arb_busy), 64'd0);
        cnt = 0;
        for (int t = 0; t < 6; t++) begin tick(); cnt += int'(bus.tx_req) + int'(bus.arb_busy); end
        chk("s3_no_launch", 64'(cnt), 64'd0);

        // Oversize length with downstream busy for 10 LAUNCH cycles
        do_reset();
        r_val[0] = 1'b1; r_len[0] = 8'd200; r_str[0] = rand_str();
        tx_busy_i = 1'b1; hold_busy = 10;
        tick();
        chk("s4_ack", 64'(bus.req_ack), 64'h1);
        first = 0; cnt = 0;
        for (int t = 2; t <= 30; t++) begin
            tick();
            if (bus.tx_req === 1'b1) begin
                cnt++;
                if (first == 0) first = t;
            end
        end
        chk("s4_txreq_tick",  64'(first),         64'd12);
        chk("s4_txreq_count", 64'(cnt),           64'd1);
        chk("s4_txlen_clamp", 64'(bus.tx_length), 64'd128);

`ifndef UART_ARB_FIXED_PRIO_EN
        // All requesters continuously valid: strict rotation with gap spacing
        do_reset();
        auto_refill = 1;
        for (int k = 0; k < N_REQ; k++) begin r_len[k] = rand_len(0); r_str[k] = rand_str(); end
        r_val = '1;
        nack = 0; last_done = -1; min_gap = 1000; n = 0;
        while (nack < 5 && n < 400) begin
            tick(); n++;
            if (bus.req_done !== '0) last_done = cyc;
            for (int k = 0; k < N_REQ; k++) begin
                if (bus.req_ack[k] === 1'b1 && nack < 5) begin
                    seq[nack] = k; nack++;
                    if (last_done >= 0 && cyc - last_done < min_gap) min_gap = cyc - last_done;
                end
            end
        end
        chk("s2_ack_count", 64'(nack), 64'd5);
        chk("s2_seq0", 64'(seq[0]), 64'd0);
        chk("s2_seq1", 64'(seq[1]), 64'd1);
        chk("s2_seq2", 64'(seq[2]), 64'd2);
        chk("s2_seq3", 64'(seq[3]), 64'd3);
        chk("s2_seq4", 64'(seq[4]), 64'd0);
        chk("s2_spacing_ge17", 64'(min_gap >= 17), 64'd1);
        auto_refill = 0; r_val = '0;
`else
        // Fixed priority: slot 0 always wins over slot 3
        do_reset();
        auto_refill = 1;
        r_len[0] = 8'd4; r_len[3] = 8'd6; r_val = 4'b1001;
        nack = 0; cnt = 0; n = 0;
        while (nack < 4 && n < 400) begin
            tick(); n++;
            if (bus.req_ack !== '0) begin nack++; if (bus.req_ack === 4'b0001) cnt++; end
        end
        chk("s6_ack_count", 64'(nack), 64'd4);
        chk("s6_all_req0",  64'(cnt),  64'd4);
        auto_refill = 0; r_val = '0;
`endif

        // Reset while waiting for tx_done; slot 3 alone afterwards
        do_reset();
        r_val[0] = 1'b1; r_len[0] = 8'd9; r_str[0] = rand_str();
        n = 0;
        while (bus.tx_req !== 1'b1 && n < 20) begin tick(); n++; end
        chk("s5_launched", 64'(n < 20), 64'd1);
        r_val[3] = 1'b1; r_len[3] = 8'd7; r_str[3] = rand_str();
        tick();
        do_reset();
        tick();
        chk("s5_ack3",  64'(bus.req_ack),  64'h8);
        chk("s5_gid3",  64'(bus.grant_id), 64'd3);
        chk("s5_done0", 64'(bus.req_done), 64'd0);

        // Randomized traffic with one reset in the middle
        do_reset();
        rand_mode = 1;
        for (int it = 0; it < 4000; it++) begin
            if (it == 2000) do_reset();
            for (int k = 0; k < N_REQ; k++) begin
                if (!r_val[k] && $urandom_range(0, 5) == 0) begin
                    r_val[k] = 1'b1; r_len[k] = rand_len(1); r_str[k] = rand_str();
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
